// File: rtl/rom_download_packer.sv
// rom_download_packer
//   Packs the byte-wide HPS ioctl ROM download into 32-bit little-endian
//   words and writes them to SDRAM through a req/ack request port. One
//   assembly register collects bytes of the current word and one output slot
//   holds the word being offered to SDRAM. ioctl_wait throttles the HPS so
//   that every accepted byte always has somewhere to go. done pulses once
//   after the download has ended and every word has been acknowledged.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   ioctl_addr     byte address of the current download byte
//   ioctl_data     download byte
//   ioctl_wr       one-cycle strobe, byte valid
//   ioctl_download high for the duration of the download
//   ioctl_wait     high = HPS must not issue the next ioctl_wr
//   sdram_addr     word address of the pending write (BASE_ADDR + word index)
//   sdram_data     word of the pending write
//   sdram_we       write enable, follows sdram_req
//   sdram_req      request, held until acknowledged
//   sdram_ack      one-cycle acceptance of the current request
//   done           one-cycle pulse when the download is fully written
module rom_download_packer #(
   parameter int unsigned BASE_ADDR        = 0,
   parameter int unsigned IOCTL_ADDR_WIDTH = 20,
   parameter int unsigned SDRAM_ADDR_WIDTH = 23
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [IOCTL_ADDR_WIDTH-1:0] ioctl_addr,
   input  logic [7:0]                  ioctl_data,
   input  logic                        ioctl_wr,
   input  logic                        ioctl_download,
   output logic                        ioctl_wait,
   output logic [SDRAM_ADDR_WIDTH-1:0] sdram_addr,
   output logic [31:0]                 sdram_data,
   output logic                        sdram_we,
   output logic                        sdram_req,
   input  logic                        sdram_ack,
   output logic                        done
);

   localparam int unsigned WA = IOCTL_ADDR_WIDTH - 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   // Assembly register. asm_cmp_q marks a complete word that could not yet
   // move into the slot (a lane-3 byte that arrived while the slot was busy).
   logic [31:0]                 asm_data_q, asm_data_d;
   logic [3:0]                  asm_mask_q, asm_mask_d;
   logic [WA-1:0]               asm_waddr_q, asm_waddr_d;
   logic                        asm_cmp_q, asm_cmp_d;

   // Output slot feeding the SDRAM request port.
   logic                        slot_q, slot_d;
   logic [31:0]                 slot_data_q, slot_data_d;
   logic [SDRAM_ADDR_WIDTH-1:0] slot_addr_q, slot_addr_d;

   logic [1:0]                  byte_lane;
   logic [WA-1:0]               byte_waddr;
   logic                        byte_v;
   logic                        new_word;
   logic                        slot_free;
   logic [3:0]                  lane_mask;
   logic [31:0]                 lane_data;
   logic [31:0]                 merged_data;
   logic                        out_valid;
   logic [31:0]                 out_data;
   logic [WA-1:0]               out_waddr;

   assign byte_lane  = ioctl_addr[1:0];
   assign byte_waddr = ioctl_addr[IOCTL_ADDR_WIDTH-1:2];
   assign byte_v     = (state_q == S_LOAD) && ioctl_wr;
   // A held word (partial or already complete) is pushed out before the
   // incoming byte starts a fresh assembly.
   assign new_word   = byte_v && (asm_mask_q != '0) &&
                       (asm_cmp_q || (byte_waddr != asm_waddr_q));
   // The slot can take a word if empty or being emptied by ack this cycle.
   assign slot_free  = !slot_q || sdram_ack;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (ioctl_download) state_d = S_LOAD;
         S_LOAD:  if (!ioctl_download) state_d = S_FLUSH;
         S_FLUSH: if ((asm_mask_q == '0) && !slot_q) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ioctl_wait = slot_q && (asm_mask_q != '0);
      sdram_req  = slot_q;
      sdram_we   = slot_q;
      sdram_addr = slot_addr_q;
      sdram_data = slot_data_q;
      done       = (state_q == S_DONE);
   end

   // ------------------------------------------------------ byte placement
   always_comb begin
      lane_mask   = '0;
      lane_data   = '0;
      merged_data = asm_data_q;
      case (byte_lane)
         2'd0: begin
            lane_mask         = 4'b0001;
            lane_data[7:0]    = ioctl_data;
            merged_data[7:0]  = ioctl_data;
         end
         2'd1: begin
            lane_mask         = 4'b0010;
            lane_data[15:8]   = ioctl_data;
            merged_data[15:8] = ioctl_data;
         end
         2'd2: begin
            lane_mask          = 4'b0100;
            lane_data[23:16]   = ioctl_data;
            merged_data[23:16] = ioctl_data;
         end
         default: begin
            lane_mask          = 4'b1000;
            lane_data[31:24]   = ioctl_data;
            merged_data[31:24] = ioctl_data;
         end
      endcase
   end

   // ------------------------------------------------- assembly / slot next
   always_comb begin
      out_valid   = 1'b0;
      out_data    = asm_data_q;
      out_waddr   = asm_waddr_q;
      asm_data_d  = asm_data_q;
      asm_mask_d  = asm_mask_q;
      asm_waddr_d = asm_waddr_q;
      asm_cmp_d   = asm_cmp_q;

      if (state_q == S_IDLE) begin
         asm_data_d  = '0;
         asm_mask_d  = '0;
         asm_waddr_d = '0;
         asm_cmp_d   = 1'b0;
      end else if (new_word) begin
         out_valid = 1'b1;
         if (slot_free) begin
            asm_data_d  = lane_data;
            asm_mask_d  = lane_mask;
            asm_waddr_d = byte_waddr;
            asm_cmp_d   = (byte_lane == 2'd3);
         end
      end else if (byte_v) begin
         if (byte_lane == 2'd3) begin
            out_valid = 1'b1;
            out_data  = merged_data;
            out_waddr = byte_waddr;
            if (slot_free) begin
               asm_data_d  = '0;
               asm_mask_d  = '0;
               asm_cmp_d   = 1'b0;
            end else begin
               // Slot busy: park the completed word until the slot frees.
               asm_data_d  = merged_data;
               asm_mask_d  = asm_mask_q | lane_mask;
               asm_waddr_d = byte_waddr;
               asm_cmp_d   = 1'b1;
            end
         end else begin
            asm_data_d  = merged_data;
            asm_mask_d  = asm_mask_q | lane_mask;
            asm_waddr_d = byte_waddr;
         end
      end else if (asm_cmp_q || ((state_q == S_FLUSH) && (asm_mask_q != '0))) begin
         out_valid = 1'b1;
         if (slot_free) begin
            asm_data_d  = '0;
            asm_mask_d  = '0;
            asm_cmp_d   = 1'b0;
         end
      end
   end

   always_comb begin
      slot_d      = slot_q;
      slot_data_d = slot_data_q;
      slot_addr_d = slot_addr_q;
      if (out_valid && slot_free) begin
         slot_d      = 1'b1;
         slot_data_d = out_data;
         slot_addr_d = SDRAM_ADDR_WIDTH'(BASE_ADDR) + SDRAM_ADDR_WIDTH'(out_waddr);
      end else if (slot_q && sdram_ack) begin
         slot_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         asm_data_q  <= '0;
         asm_mask_q  <= '0;
         asm_waddr_q <= '0;
         asm_cmp_q   <= 1'b0;
         slot_q      <= 1'b0;
         slot_data_q <= '0;
         slot_addr_q <= '0;
      end else begin
         asm_data_q  <= asm_data_d;
         asm_mask_q  <= asm_mask_d;
         asm_waddr_q <= asm_waddr_d;
         asm_cmp_q   <= asm_cmp_d;
         slot_q      <= slot_d;
         slot_data_q <= slot_data_d;
         slot_addr_q <= slot_addr_d;
      end
   end

endmodule

// File: tb/tb_rom_download_packer.sv
// Testbench for rom_download_packer: directed byte streams, a byte-level
// model of the expected SDRAM write sequence, and a per-cycle compare process.
`timescale 1ns/1ps
module tb_rom_download_packer;

   localparam int unsigned AW = 20;
   localparam int unsigned SW = 23;
   localparam logic [SW-1:0] BASE = 23'h7FFFF0;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] ioctl_addr;
   logic [7:0]    ioctl_data;
   logic          ioctl_wr;
   logic          ioctl_download;
   logic          ioctl_wait;
   logic [SW-1:0] sdram_addr;
   logic [31:0]   sdram_data;
   logic          sdram_we;
   logic          sdram_req;
   logic          sdram_ack;
   logic          done;

   always #5 clk = ~clk;

   rom_download_packer #(
      .BASE_ADDR(32'h007FFFF0),
      .IOCTL_ADDR_WIDTH(AW),
      .SDRAM_ADDR_WIDTH(SW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .ioctl_addr(ioctl_addr),
      .ioctl_data(ioctl_data),
      .ioctl_wr(ioctl_wr),
      .ioctl_download(ioctl_download),
      .ioctl_wait(ioctl_wait),
      .sdram_addr(sdram_addr),
      .sdram_data(sdram_data),
      .sdram_we(sdram_we),
      .sdram_req(sdram_req),
      .sdram_ack(sdram_ack),
      .done(done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------- model
   typedef struct packed {
      logic [SW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   wr_t           exp_q[$];
   logic [31:0]   m_data  = '0;
   logic [3:0]    m_mask  = '0;
   logic [AW-3:0] m_waddr = '0;

   task automatic model_push();
      wr_t e;
      if (m_mask != 4'b0) begin
         e.addr = BASE + SW'(m_waddr);
         e.data = m_data;
         exp_q.push_back(e);
      end
      m_mask = '0;
      m_data = '0;
   endtask

   task automatic model_byte(input logic [AW-1:0] a, input logic [7:0] d);
      int unsigned k;
      logic [AW-3:0] w;
      k = int'(a[1:0]);
      w = a[AW-1:2];
      if ((m_mask != 4'b0) && (w != m_waddr)) model_push();
      m_waddr = w;
      m_data[8*k +: 8] = d;
      m_mask[k] = 1'b1;
      if (k == 3) model_push();
   endtask

   // ------------------------------------------------------ ack responder
   int unsigned ack_delay = 0;
   initial begin
      int unsigned cnt;
      cnt = 0;
      sdram_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (sdram_ack || reset) cnt = 0;
         sdram_ack = 1'b0;
         if (sdram_req && !reset) begin
            cnt++;
            if (cnt > ack_delay) sdram_ack = 1'b1;
         end else begin
            cnt = 0;
         end
      end
   end

   // ---------------------------------------------------- compare process
   logic          prev_req = 1'b0, prev_ack = 1'b0, prev_done = 1'b0, prev_reset = 1'b1;
   logic [SW-1:0] prev_addr = '0;
   logic [31:0]   prev_data = '0;
   int            acc_cnt = 0;
   int            done_cnt = 0;
   logic          wait_seen = 1'b0;
   logic [SW-1:0] last_addr = '0;
   logic [31:0]   last_data = '0;

   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            check("we_follows_req", 64'(sdram_we), 64'(sdram_req));
            if (prev_req && !prev_ack && !prev_reset) begin
               check("req_held", 64'(sdram_req), 64'(1));
               check("addr_stable", 64'(sdram_addr), 64'(prev_addr));
               check("data_stable", 64'(sdram_data), 64'(prev_data));
            end
            if (sdram_req && sdram_ack) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                           sdram_addr, sdram_data);
               end else begin
                  e = exp_q.pop_front();
                  check("write_addr", 64'(sdram_addr), 64'(e.addr));
                  check("write_data", 64'(sdram_data), 64'(e.data));
               end
               acc_cnt++;
               last_addr = sdram_addr;
               last_data = sdram_data;
            end
            if (done) begin
               done_cnt++;
               check("done_queue_empty", 64'(exp_q.size()), 64'(0));
               check("done_single_cycle", 64'(prev_done), 64'(0));
               check("done_no_req", 64'(sdram_req), 64'(0));
            end
            if (ioctl_wait) wait_seen = 1'b1;
         end
         prev_req   = sdram_req;
         prev_ack   = sdram_ack;
         prev_done  = done;
         prev_reset = reset;
         prev_addr  = sdram_addr;
         prev_data  = sdram_data;
      end
   end

   // ------------------------------------------------------ stimulus tasks
   task automatic tick(input int unsigned n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_download();
      ioctl_download = 1'b1;
      m_mask = '0;
      m_data = '0;
      tick(2);
   endtask

   task automatic send_byte(input logic [AW-1:0] a, input logic [7:0] d, input bit fall = 1'b0);
      int unsigned n;
      n = 0;
      while (ioctl_wait && n < 200) begin
         tick();
         n++;
      end
      check("wait_release", 64'(ioctl_wait), 64'(0));
      ioctl_addr = a;
      ioctl_data = d;
      ioctl_wr   = 1'b1;
      model_byte(a, d);
      if (fall) begin
         ioctl_download = 1'b0;
         model_push();
      end
      tick();
      ioctl_wr = 1'b0;
   endtask

   task automatic end_download();
      ioctl_download = 1'b0;
      model_push();
      tick();
   endtask

   task automatic wait_done(input int target);
      int unsigned n;
      n = 0;
      while (done_cnt < target && n < 500) begin
         tick();
         n++;
      end
      check("done_count", 64'(done_cnt), 64'(target));
   endtask

   task automatic wait_acc(input int target);
      int unsigned n;
      n = 0;
      while (acc_cnt < target && n < 200) begin
         tick();
         n++;
      end
      check("accept_count", 64'(acc_cnt), 64'(target));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   // ---------------------------------------------------------- main test
   logic [7:0] t1d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   initial begin
      int n;
      int acc0;
      reset          = 1'b1;
      ioctl_addr     = '0;
      ioctl_data     = '0;
      ioctl_wr       = 1'b0;
      ioctl_download = 1'b0;
      tick(3);
      check("rst_req", 64'(sdram_req), 64'(0));
      check("rst_we", 64'(sdram_we), 64'(0));
      check("rst_wait", 64'(ioctl_wait), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_addr", 64'(sdram_addr), 64'(0));
      check("rst_data", 64'(sdram_data), 64'(0));
      reset = 1'b0;
      tick(2);

      // T1: one aligned word, ack 2 cycles after req
      ack_delay = 2;
      wait_seen = 1'b0;
      start_download();
      for (int i = 0; i < 4; i++) send_byte(AW'(i), t1d[i]);
      n = 0;
      while (sdram_req && n < 50) begin
         n++;
         tick();
      end
      check("t1_req_cycles", 64'(n), 64'(3));
      check("t1_addr", 64'(last_addr), 64'(BASE));
      check("t1_data", 64'(last_data), 64'h44332211);
      end_download();
      wait_done(1);
      check("t1_wait_never", 64'(wait_seen), 64'(0));

      // T2: backpressure with ack withheld 20 cycles
      ack_delay = 20;
      acc0 = acc_cnt;
      start_download();
      for (int i = 0; i < 5; i++) send_byte(AW'(i), 8'(8'h20 + i));
      check("t2_wait_rise", 64'(ioctl_wait), 64'(1));
      n = 0;
      while (ioctl_wait && n < 100) begin
         tick();
         n++;
      end
      check("t2_wait_cycles", 64'(n), 64'(20));
      check("t2_first_ack", 64'(acc_cnt), 64'(acc0 + 1));
      for (int i = 5; i < 8; i++) send_byte(AW'(i), 8'(8'h20 + i));
      wait_acc(acc0 + 2);
      check("t2_addr2", 64'(last_addr), 64'(BASE + 23'd1));
      check("t2_data2", 64'(last_data), 64'h27262524);
      ack_delay = 1;
      end_download();
      wait_done(2);

      // T3: partial trailing word flushed by download fall
      acc0 = acc_cnt;
      start_download();
      for (int i = 0; i < 6; i++) send_byte(AW'(i), 8'(i + 1));
      end_download();
      wait_done(3);
      check("t3_writes", 64'(acc_cnt), 64'(acc0 + 2));
      check("t3_addr", 64'(last_addr), 64'(BASE + 23'd1));
      check("t3_data", 64'(last_data), 64'h00000605);

      // T4: word address jump flushes a partial word
      acc0 = acc_cnt;
      start_download();
      send_byte(AW'(0), 8'hAA);
      send_byte(AW'(8), 8'hBB);
      wait_acc(acc0 + 1);
      check("t4_first_addr", 64'(last_addr), 64'(BASE));
      check("t4_first_data", 64'(last_data), 64'h000000AA);
      end_download();
      wait_done(4);
      check("t4_second_addr", 64'(last_addr), 64'(BASE + 23'd2));
      check("t4_second_data", 64'(last_data), 64'h000000BB);

      // T5: reload on the ack cycle, then a lane-3 word parked behind a busy slot
      ack_delay = 0;
      acc0 = acc_cnt;
      start_download();
      for (int i = 0; i < 4; i++) send_byte(AW'(i), t1d[i]);
      send_byte(AW'(7), 8'h77);
      check("t5_req_continuous", 64'(sdram_req), 64'(1));
      check("t5_reload_addr", 64'(sdram_addr), 64'(BASE + 23'd1));
      check("t5_reload_data", 64'(sdram_data), 64'h77000000);
      wait_acc(acc0 + 2);
      ack_delay = 4;
      send_byte(AW'(20'h13), 8'h55);
      send_byte(AW'(20'h17), 8'h66);
      check("t5_parked_wait", 64'(ioctl_wait), 64'(1));
      wait_acc(acc0 + 4);
      check("t5_last_addr", 64'(last_addr), 64'(BASE + 23'd5));
      check("t5_last_data", 64'(last_data), 64'h66000000);
      ack_delay = 1;
      end_download();
      wait_done(5);

      // T6: reset while a request is pending
      ack_delay = 50;
      start_download();
      for (int i = 0; i < 4; i++) send_byte(AW'(i), 8'(8'hC0 + i));
      send_byte(AW'(4), 8'hC4);
      check("t6_req_before", 64'(sdram_req), 64'(1));
      check("t6_wait_before", 64'(ioctl_wait), 64'(1));
      reset = 1'b1;
      ioctl_download = 1'b0;
      exp_q.delete();
      m_mask = '0;
      m_data = '0;
      tick();
      check("t6_req_after", 64'(sdram_req), 64'(0));
      check("t6_wait_after", 64'(ioctl_wait), 64'(0));
      check("t6_done_after", 64'(done), 64'(0));
      reset = 1'b0;
      tick(3);
      check("t6_no_done", 64'(done_cnt), 64'(5));
      ack_delay = 1;
      acc0 = acc_cnt;
      start_download();
      send_byte(AW'(20'h41), 8'hE1);
      end_download();
      wait_done(6);
      check("t6_writes", 64'(acc_cnt), 64'(acc0 + 1));
      check("t6_wrap_addr", 64'(last_addr), 64'(0));
      check("t6_fresh_data", 64'(last_data), 64'h0000E100);

      // T7: last byte on the same cycle as the download fall
      start_download();
      send_byte(AW'(20'h21), 8'h5A);
      send_byte(AW'(20'h22), 8'hA5, 1'b1);
      wait_done(7);
      check("t7_addr", 64'(last_addr), 64'(BASE + 23'd8));
      check("t7_data", 64'(last_data), 64'h00A55A00);

      tick(5);
      check("final_queue_empty", 64'(exp_q.size()), 64'(0));
      check("final_done_count", 64'(done_cnt), 64'(7));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
